// File: rtl/tetris_pkg.sv
// Shared piece encoding, bag constants and FSM state type for the piece randomizer.
package tetris_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_t;

  typedef enum logic {
    FILL = 1'b0,
    IDLE = 1'b1
  } bag_state_t;

  localparam int         NUM_PIECES  = 7;
  localparam logic [6:0] ALL_USED    = 7'h7F;
  localparam logic [2:0] INVALID_RND = 3'd7;

  // Lowest-index piece not yet dealt in the current bag.
  function automatic logic [2:0] lowest_unused(input logic [6:0] used);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (!used[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/piece_fifo.sv
// QDEPTH x 3-bit shift queue; entry 0 is the head, vacated slots are refilled with 0.
module piece_fifo
  import tetris_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int CW = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [2:0]    din,
  output logic [2:0]    head,
  output logic [CW-1:0] count,
  output logic          rdy
);

  logic [2:0]    q    [QDEPTH];
  logic [2:0]    q_nx [QDEPTH];
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] wr_idx;

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) q_nx[i] = q[i];
    cnt_nx = count;
    if (pop) begin
      for (int i = 0; i < QDEPTH - 1; i++) q_nx[i] = q[i + 1];
      q_nx[QDEPTH-1] = 3'd0;
      cnt_nx = count - CW'(1);
    end
    // The push slot is computed after the pop shift so push+pop at count 1 lands at the head.
    wr_idx = cnt_nx;
    if (push) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (CW'(i) == wr_idx) q_nx[i] = din;
      end
      cnt_nx = cnt_nx + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) q[i] <= 3'd0;
      count <= '0;
      rdy   <= 1'b0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) q[i] <= q_nx[i];
      count <= cnt_nx;
      rdy   <= (cnt_nx != '0);
    end
  end

  assign head = q[0];

endmodule

// File: rtl/piece_bag.sv
// 7-bag piece randomizer: filters the raw 3-bit source, buffers a preview queue, deals on next_req.
// Optional build macro PIECE_BAG_STATS_EN adds bag_count and forced_cnt outputs.
module piece_bag
  import tetris_pkg::*;
#(
  parameter int QDEPTH    = 2,
  parameter int MAX_TRIES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rnd,
  input  logic       next_req,
  output logic       rdy,
  output logic [2:0] cur_piece,
  output logic       piece_valid,
  output logic [2:0] next_piece
`ifdef PIECE_BAG_STATS_EN
  ,
  output logic [7:0] bag_count,
  output logic [7:0] forced_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  bag_state_t    state, state_nx;
  logic [6:0]    used, used_set, used_nx;
  logic [7:0]    avail;
  logic [TW-1:0] try_cnt, try_nx;
  logic [CW-1:0] fifo_count;
  logic          sampling, hit, force_pick, push, pop, wrap;
  logic [2:0]    pick;

  // Sample qualification and bag bookkeeping
  always_comb begin
    sampling   = (state == FILL);
    pop        = next_req & rdy;
    // Bit 7 is tied low so the invalid code 7 can never hit.
    avail      = {1'b0, ~used};
    hit        = avail[rnd];
    force_pick = sampling && !hit && (try_cnt == TW'(MAX_TRIES - 1));
    push       = sampling && (hit || force_pick);
    pick       = hit ? rnd : lowest_unused(used);
    used_set   = used | (7'd1 << pick);
    wrap       = push && (used_set == ALL_USED);

    used_nx = used;
    if (push) used_nx = wrap ? 7'd0 : used_set;

    try_nx = try_cnt;
    if (!sampling || push) try_nx = '0;
    else                   try_nx = try_cnt + TW'(1);

    state_nx = state;
    case (state)
      FILL: if (push && !pop && (fifo_count == CW'(QDEPTH - 1))) state_nx = IDLE;
      IDLE: if (pop) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      used        <= 7'd0;
      try_cnt     <= '0;
      cur_piece   <= 3'd0;
      piece_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      used    <= used_nx;
      try_cnt <= try_nx;
      if (pop) begin
        cur_piece   <= next_piece;
        piece_valid <= 1'b1;
      end
    end
  end

  piece_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pick),
    .head  (next_piece),
    .count (fifo_count),
    .rdy   (rdy)
  );

`ifdef PIECE_BAG_STATS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bag_count  <= 8'd0;
      forced_cnt <= 8'd0;
    end else begin
      if (wrap)       bag_count  <= bag_count + 8'd1;
      if (force_pick) forced_cnt <= sat_inc(forced_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_piece_bag.sv
// Directed bench for piece_bag: reset, fill/idle, forced picks, bag filtering, async reset.
module tb_piece_bag;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rnd;
  logic       next_req;
  logic       rdy;
  logic [2:0] cur_piece;
  logic       piece_valid;
  logic [2:0] next_piece;
`ifdef PIECE_BAG_STATS_EN
  logic [7:0] bag_count;
  logic [7:0] forced_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] rnd_v [10] = '{3'd3, 3'd3, 3'd5, 3'd7, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd3};
  logic [2:0] cur_e [10] = '{3'd0, 3'd3, 3'd3, 3'd5, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
  logic       rdy_e [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [2:0] nxt_e [10] = '{3'd3, 3'd0, 3'd5, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd3};

  piece_bag #(.QDEPTH(2), .MAX_TRIES(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .rnd         (rnd),
    .next_req    (next_req),
    .rdy         (rdy),
    .cur_piece   (cur_piece),
    .piece_valid (piece_valid),
    .next_piece  (next_piece)
`ifdef PIECE_BAG_STATS_EN
    ,
    .bag_count   (bag_count),
    .forced_cnt  (forced_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

`ifdef PIECE_BAG_STATS_EN
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
`endif

  task automatic chk_out(input string tag, input logic r, input logic [2:0] c,
                         input logic v, input logic [2:0] n);
    chk1({tag, "_rdy"}, rdy, r);
    chk3({tag, "_cur"}, cur_piece, c);
    chk1({tag, "_pv"}, piece_valid, v);
    chk3({tag, "_next"}, next_piece, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b0; rnd = 3'd7; next_req = 1'b0;
    tick(); tick();
    chk_out("rst", 1'b0, 3'd0, 1'b0, 3'd0);

    // Incrementing stream: fill to two entries, then idle
    rnd = 3'd0; reset = 1'b1;
    tick();
    chk_out("a_e1", 1'b1, 3'd0, 1'b0, 3'd0);
    rnd = 3'd1; tick();
    rnd = 3'd2; tick(); tick();
    chk_out("a_idle", 1'b1, 3'd0, 1'b0, 3'd0);
    next_req = 1'b1; tick(); next_req = 1'b0;
    chk_out("a_pop0", 1'b1, 3'd0, 1'b1, 3'd1);
    tick();
    chk_out("a_refill", 1'b1, 3'd0, 1'b1, 3'd1);
    next_req = 1'b1; tick(); next_req = 1'b0;
    chk_out("a_pop1", 1'b1, 3'd1, 1'b1, 3'd2);

    // Asynchronous reset between edges, then rnd stuck at 7
    #2 reset = 1'b0;
    #1 chk_out("b_async", 1'b0, 3'd0, 1'b0, 3'd0);
    rnd = 3'd7; tick();
    reset = 1'b1; next_req = 1'b1; tick(); next_req = 1'b0;
    chk1("b_ignored_pv", piece_valid, 1'b0);
    chk1("b_ignored_rdy", rdy, 1'b0);
    repeat (13) tick();
    chk1("b_e14_rdy", rdy, 1'b0);
    tick();
    chk_out("b_force0", 1'b1, 3'd0, 1'b0, 3'd0);
    next_req = 1'b1; tick(); next_req = 1'b0;
    chk_out("b_pop0", 1'b0, 3'd0, 1'b1, 3'd0);
    repeat (13) tick();
    chk1("b_e29_rdy", rdy, 1'b0);
    tick();
    chk_out("b_force1", 1'b1, 3'd0, 1'b1, 3'd1);
`ifdef PIECE_BAG_STATS_EN
    chk8("b_forced_cnt", forced_cnt, 8'd2);
    chk8("b_bag_count", bag_count, 8'd0);
`endif

    // Bag filtering with continuous requests
    tick(); reset = 1'b0; tick();
    rnd = rnd_v[0]; next_req = 1'b1; reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1($sformatf("c_rdy%0d", i), rdy, rdy_e[i]);
      chk3($sformatf("c_cur%0d", i), cur_piece, cur_e[i]);
      chk3($sformatf("c_next%0d", i), next_piece, nxt_e[i]);
      chk1($sformatf("c_pv%0d", i), piece_valid, (i != 0));
      if (i < 9) rnd = rnd_v[i + 1];
    end
`ifdef PIECE_BAG_STATS_EN
    chk8("c_bag_count", bag_count, 8'd1);
    chk8("c_forced_cnt", forced_cnt, 8'd0);
`endif

    // Reset mid-fill; whole bag must be available again afterwards
    rnd = 3'd7; next_req = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1 chk_out("d_async", 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    reset = 1'b1; next_req = 1'b1; rnd = 3'd6;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1($sformatf("d_rdy%0d", i), rdy, (i < 7));
      chk3($sformatf("d_cur%0d", i), cur_piece, (i == 0) ? 3'd0 : 3'(7 - i));
      chk3($sformatf("d_next%0d", i), next_piece, (i < 7) ? 3'(6 - i) : 3'd0);
      chk1($sformatf("d_pv%0d", i), piece_valid, (i != 0));
      rnd = (i < 6) ? 3'(5 - i) : 3'd7;
    end
    next_req = 1'b0;
`ifdef PIECE_BAG_STATS_EN
    chk8("d_bag_count", bag_count, 8'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piece_bag.md
Name: piece_bag

Overview:
- Consumer end of the free-running 3-bit random piece source.
- Samples the raw random value every cycle and rejects value 7 and any piece already dealt in the current bag (7-bag randomizer).
- Buffers accepted pieces in a small preview queue and hands them to game control through a req/ready handshake.
- Sits between the random source and the spawn logic; the preview head drives the "next piece" display.

Parameters:
- QDEPTH, 2: preview queue depth in entries; minimum 1.
- MAX_TRIES, 15: consecutive rejected samples before a forced pick; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- rnd  in  3  raw random value from the piece generator, valid every cycle.
- next_req  in  1  game requests a new piece; single-cycle pulse.
- rdy  out  1  queue non-empty; next_req is accepted only when rdy=1.
- cur_piece  out  3  piece popped by the last accepted request.
- piece_valid  out  1  cur_piece holds a dealt piece.
- next_piece  out  3  queue head (preview); 0 when the queue is empty.

Behaviour:
- Reset values:
  - Outputs: rdy=0, cur_piece=0, piece_valid=0, next_piece=0.
  - Internal: used mask=0, try_cnt=0, queue count=0.
  - State: FILL.
- State FILL (count<QDEPTH):
  - Sample rnd each cycle. The sample is accepted when rnd!=7 and used[rnd]=0.
  - Otherwise, if try_cnt==MAX_TRIES-1, force-accept the lowest-index unused piece.
  - Otherwise, reject and increment try_cnt.
- On accept:
  - Push the piece to the queue tail, set its used bit, and clear try_cnt.
  - If the used mask becomes 7'h7F, clear it in the same cycle; the next bag starts with the following sample.
- State IDLE (count==QDEPTH): sampling stops and try_cnt holds at 0.
  - IDLE→FILL when a pop occurs.
  - FILL→IDLE when a push makes count==QDEPTH with no simultaneous pop.
- Pop: next_req=1 and rdy=1.
  - Registered next edge: cur_piece<=head, piece_valid<=1 (sticky until reset), queue shifts.
- next_req with rdy=0 is ignored. It is not remembered and has no side effects.
- Simultaneous push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - When count==1, the pushed entry becomes the new head; next_piece shows it one cycle later.
- rdy and next_piece are registered and track count>0 and the head with no extra delay beyond the register edge.
- Latency:
  - The first piece becomes available 1..MAX_TRIES cycles after reset release.
  - Refill latency is bounded by MAX_TRIES cycles per entry.
- Output cur_piece is never 7. Within any 7 consecutive pops aligned to a bag boundary, each of 0..6 appears exactly once.
- Asserting reset mid-fill or mid-pop discards the queue, used mask and cur_piece immediately. After release, operation restarts from FILL.

Optional Feature:
- Macro: PIECE_BAG_STATS_EN.
- Defined: adds output bag_count (8 bits), which increments when the used mask wraps to 0 and wraps 255→0. Also adds forced_cnt (8 bits), which counts forced picks and saturates at 255. Both reset to 0.
- Undefined: neither port nor its counters exist; the rest of the behaviour is identical.

Decomposition:
- Package tetris_pkg holds:
  - piece_t encoding I=0, O=1, T=2, S=3, Z=4, J=5, L=6.
  - NUM_PIECES=7.
  - ALL_USED=7'h7F.
  - INVALID_RND=3'd7.
- Sub-module piece_fifo: parameterised QDEPTH×3-bit shift queue with push/pop/count/head, same async active-low reset.
- The bag mask, try counter and FSM stay in piece_bag.

Test Plan:
- Reset release, rnd stream 0,1,2,… → rdy=1 on the edge after the first accept, next_piece=0; state IDLE after 2 accepts (count=2).
- rnd held at 7 → first piece 0, forced after 15 cycles; second piece 1, forced 15 cycles later; forced_cnt=2 if PIECE_BAG_STATS_EN is defined.
- rnd 3,3,5,7,0,1,2,4,6 with continuous next_req → cur_piece sequence 3,5,0,1,2,4,6; repeat 3 and 7 rejected; used mask clears after 6; bag_count=1.
- next_req pulsed while rdy=0 just after reset → no pop, piece_valid stays 0, no deferred pop later.
- Queue count=1 with next_req asserted in the same cycle an accept occurs → count stays 1, cur_piece=old head, next_piece=new piece.
- reset driven low mid-FILL → all outputs 0 asynchronously (before the next clk edge); after release, the bag restarts and 0..6 are all still available.
